// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant owner, bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Fetch vs load/store priority pick with anti-starvation counter for fetch.
// Latency: pick is combinational; counter updates on the grant strobe edge.
// Backpressure: none; the caller only strobes grant when it can take a request.
module mem_arb_prio #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic ls_req,
   input  logic grant,
   output logic pick_if
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt;

   // Load/store wins by default; fetch wins when alone or once it has lost STARVE_LIMIT times in a row.
   assign pick_if = if_req & (~ls_req | (starve_cnt == CW'(STARVE_LIMIT)));

   // Count consecutive LS grants that left a fetch waiting; any other grant clears the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (pick_if || !if_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between instruction fetch and load/store, one transaction at a time.
// Latency: request to ack pulse is at least 3 cycles (grant, accept, response, registered ack).
// Backpressure: payload held stable while mem_ready is low; stall holds the core until the ack pulse.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [MASK_W-1:0] ls_wmask,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e        state;
   owner_e        owner;
   logic [TW-1:0] tmo_cnt;
   logic          pick_if;
   logic          grant;

   // No grant during the ack cycle: the requester is still dropping its req on that edge.
   assign grant = (state == IDLE) & (if_req | ls_req) & ~(if_ack | ls_ack);

   // Core freezes while any request is outstanding, released in the ack cycle.
   assign stall = (if_req | ls_req) & ~(if_ack | ls_ack);

   mem_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk     (clk),
      .rst     (rst),
      .if_req  (if_req),
      .ls_req  (ls_req),
      .grant   (grant),
      .pick_if (pick_if)
   );

   // Transaction FSM: latch the winner, present it on the port, then wait for response or timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         tmo_cnt   <= '0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         if_ack    <= 1'b0;
         if_rdata  <= '0;
         ls_ack    <= 1'b0;
         ls_rdata  <= '0;
         err       <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         ls_ack <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner     <= pick_if ? OWN_IF : OWN_LS;
                  mem_addr  <= pick_if ? if_addr : ls_addr;
                  mem_we    <= pick_if ? 1'b0 : ls_we;
                  mem_wdata <= pick_if ? '0 : ls_wdata;
                  mem_wmask <= pick_if ? '0 : ls_wmask;
                  mem_valid <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  tmo_cnt   <= '0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (mem_rvalid) begin
                  if (owner == OWN_IF) begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end else begin
                     ls_rdata <= mem_rdata;
                     ls_ack   <= 1'b1;
                  end
                  state <= IDLE;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  // Abort: the owner still gets its ack so the core can move on, flagged by err.
                  if (owner == OWN_IF) begin
                     if_rdata <= '0;
                     if_ack   <= 1'b1;
                  end else begin
                     ls_rdata <= '0;
                     ls_ack   <= 1'b1;
                  end
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = '0;
   logic        if_ack;
   logic [63:0] if_rdata;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [63:0] ls_addr = '0;
   logic [63:0] ls_wdata = '0;
   logic [7:0]  ls_wmask = '0;
   logic        ls_ack;
   logic [63:0] ls_rdata;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [63:0] mem_addr;
   logic        mem_we;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        stall;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .stall(stall), .err(err)
   );

   typedef struct {
      logic        if_req;
      logic [63:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [63:0] ls_addr;
      logic [63:0] ls_wdata;
      logic [7:0]  ls_wmask;
      int          rdy_dly;
      int          rv_dly;
      logic [63:0] rsp;
      logic        tmo;
      logic        exp_ls;
      logic [63:0] exp_addr;
      logic        exp_we;
      logic [7:0]  exp_wmask;
      logic [63:0] exp_wdata;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic ir, input logic [63:0] ia, input logic lr, input logic lw,
                                input logic [63:0] la, input logic [63:0] ld, input logic [7:0] lm,
                                input int rd, input int rv, input logic [63:0] rsp, input logic tmo,
                                input logic e_ls, input logic [63:0] e_addr, input logic e_we,
                                input logic [7:0] e_mask, input logic [63:0] e_wdata,
                                input logic [63:0] e_rdata, input logic e_err);
      vec_t v;
      v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_addr = la;
      v.ls_wdata = ld; v.ls_wmask = lm; v.rdy_dly = rd; v.rv_dly = rv; v.rsp = rsp; v.tmo = tmo;
      v.exp_ls = e_ls; v.exp_addr = e_addr; v.exp_we = e_we; v.exp_wmask = e_mask;
      v.exp_wdata = e_wdata; v.exp_rdata = e_rdata; v.exp_err = e_err;
      return v;
   endfunction

   // One full transaction: drive requests, play the memory side, check payload and the ack.
   task automatic do_txn(input vec_t v);
      int n;
      if_req = v.if_req; if_addr = v.if_addr;
      ls_req = v.ls_req; ls_we = v.ls_we; ls_addr = v.ls_addr;
      ls_wdata = v.ls_wdata; ls_wmask = v.ls_wmask;
      cycle();
      chk("ack_single_pulse", if_ack | ls_ack | err, 1'b0);
      chk("stall_pending", stall, 1'b1);
      n = 0;
      while (!mem_valid && n < 8) begin
         cycle();
         n++;
      end
      chk("grant_wait", mem_valid, 1'b1);
      chk("req_addr", mem_addr, v.exp_addr);
      chk("req_we", mem_we, v.exp_we);
      chk("req_wmask", mem_wmask, v.exp_wmask);
      chk("req_wdata", mem_wdata, v.exp_wdata);
      for (int i = 0; i < v.rdy_dly; i++) begin
         mem_rvalid = (i == 0);
         mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
         cycle();
         chk("hold_valid", mem_valid, 1'b1);
         chk("hold_addr", mem_addr, v.exp_addr);
         chk("hold_we", mem_we, v.exp_we);
         chk("hold_wmask", mem_wmask, v.exp_wmask);
      end
      mem_rvalid = 1'b0;
      mem_ready  = 1'b1;
      cycle();
      mem_ready = 1'b0;
      chk("valid_drop", mem_valid, 1'b0);
      chk("stall_resp", stall, 1'b1);
      if (!v.tmo) begin
         repeat (v.rv_dly) begin
            cycle();
            chk("no_early_ack", if_ack | ls_ack, 1'b0);
         end
         mem_rvalid = 1'b1;
         mem_rdata  = v.rsp;
         cycle();
         mem_rvalid = 1'b0;
         mem_rdata  = {$urandom, $urandom};
      end else begin
         n = 0;
         while (!(if_ack | ls_ack) && n < 300) begin
            cycle();
            n++;
         end
         chk("tmo_cycles", n, 255);
      end
      chk("if_ack", if_ack, !v.exp_ls);
      chk("ls_ack", ls_ack, v.exp_ls);
      chk("rdata", v.exp_ls ? ls_rdata : if_rdata, v.exp_rdata);
      chk("err", err, v.exp_err);
      chk("stall_ack", stall, 1'b0);
      if (v.exp_ls) ls_req = 1'b0;
      else          if_req = 1'b0;
      if (v.tmo) begin
         mem_rvalid = 1'b1;
         mem_rdata  = '1;
         cycle();
         mem_rvalid = 1'b0;
         chk("late_rvalid_ack", if_ack | ls_ack | err, 1'b0);
         cycle();
         chk("late_rvalid_ack2", if_ack | ls_ack | err, 1'b0);
         chk("late_rvalid_valid", mem_valid, 1'b0);
      end
   endtask

   vec_t tbl[12];

   initial begin
      int n;
      logic        if_pend, ls_pend, m_we, pick_if;
      logic [63:0] m_if_addr, m_ls_addr, m_wdata;
      logic [7:0]  m_wmask;
      int          starve;
      vec_t        v;

      tbl[0]  = mkv(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 0, 2, 64'h13, 1'b0,
                    1'b0, 64'h8000_0000, 1'b0, 8'h00, 64'h0, 64'h13, 1'b0);
      tbl[1]  = mkv(1'b1, 64'h8000_0004, 1'b1, 1'b0, 64'h1000, 64'h0, 8'h00, 0, 1, 64'h1111_2222_3333_4444, 1'b0,
                    1'b1, 64'h1000, 1'b0, 8'h00, 64'h0, 64'h1111_2222_3333_4444, 1'b0);
      tbl[2]  = mkv(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1, 0, 64'h93, 1'b0,
                    1'b0, 64'h8000_0004, 1'b0, 8'h00, 64'h0, 64'h93, 1'b0);
      tbl[3]  = mkv(1'b0, 64'h0, 1'b1, 1'b1, 64'h1008, 64'hDEAD_BEEF, 8'h0F, 3, 1, 64'h0, 1'b0,
                    1'b1, 64'h1008, 1'b1, 8'h0F, 64'hDEAD_BEEF, 64'h0, 1'b0);
      tbl[4]  = mkv(1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h2000, 64'h0, 8'h00, 0, 0, 64'hA0, 1'b0,
                    1'b1, 64'h2000, 1'b0, 8'h00, 64'h0, 64'hA0, 1'b0);
      tbl[5]  = mkv(1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h2008, 64'h0, 8'h00, 0, 0, 64'hA1, 1'b0,
                    1'b1, 64'h2008, 1'b0, 8'h00, 64'h0, 64'hA1, 1'b0);
      tbl[6]  = mkv(1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h2010, 64'h0, 8'h00, 0, 0, 64'hA2, 1'b0,
                    1'b1, 64'h2010, 1'b0, 8'h00, 64'h0, 64'hA2, 1'b0);
      tbl[7]  = mkv(1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h2018, 64'h0, 8'h00, 0, 0, 64'hA3, 1'b0,
                    1'b1, 64'h2018, 1'b0, 8'h00, 64'h0, 64'hA3, 1'b0);
      tbl[8]  = mkv(1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h2020, 64'h0, 8'h00, 0, 0, 64'hF0, 1'b0,
                    1'b0, 64'h8000_0008, 1'b0, 8'h00, 64'h0, 64'hF0, 1'b0);
      tbl[9]  = mkv(1'b1, 64'h8000_000C, 1'b1, 1'b0, 64'h2020, 64'h0, 8'h00, 0, 0, 64'hA4, 1'b0,
                    1'b1, 64'h2020, 1'b0, 8'h00, 64'h0, 64'hA4, 1'b0);
      tbl[10] = mkv(1'b1, 64'h8000_000C, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 0, 0, 64'hF1, 1'b0,
                    1'b0, 64'h8000_000C, 1'b0, 8'h00, 64'h0, 64'hF1, 1'b0);
      tbl[11] = mkv(1'b0, 64'h0, 1'b1, 1'b0, 64'h3000, 64'h0, 8'h00, 0, 0, 64'h0, 1'b1,
                    1'b1, 64'h3000, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);

      // Reset state
      repeat (2) cycle();
      chk("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_wmask", mem_wmask, 8'h00);
      chk("rst_acks", {if_ack, ls_ack, err}, 3'b000);
      chk("rst_rdata", if_rdata | ls_rdata, 64'h0);
      chk("rst_stall", stall, 1'b0);
      rst = 1'b0;
      cycle();

      for (int i = 0; i < 12; i++) do_txn(tbl[i]);

      // Reset while the request is presented: mem_valid must drop without a clock edge.
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h4000;
      n = 0;
      while (!mem_valid && n < 8) begin
         cycle();
         n++;
      end
      chk("rq_grant", mem_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("rq_rst_valid", mem_valid, 1'b0);
      chk("rq_rst_addr", mem_addr, 64'h0);
      ls_req = 1'b0;
      cycle();
      rst = 1'b0;
      cycle();

      // Reset while waiting for the response: the late response must not produce an ack.
      ls_req = 1'b1; ls_addr = 64'h5000;
      n = 0;
      while (!mem_valid && n < 8) begin
         cycle();
         n++;
      end
      chk("rr_grant", mem_valid, 1'b1);
      mem_ready = 1'b1;
      cycle();
      mem_ready = 1'b0;
      chk("rr_in_resp", mem_valid, 1'b0);
      rst = 1'b1;
      ls_req = 1'b0;
      cycle();
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h1234;
      cycle();
      mem_rvalid = 1'b0;
      chk("rr_no_ack", if_ack | ls_ack | err, 1'b0);
      cycle();
      chk("rr_no_ack2", if_ack | ls_ack | err, 1'b0);
      chk("rr_rdata", ls_rdata, 64'h0);
      chk("rr_idle", mem_valid, 1'b0);

      // Randomized traffic against a grant-order model.
      if_pend = 1'b0; ls_pend = 1'b0; starve = 0;
      m_if_addr = '0; m_ls_addr = '0; m_wdata = '0; m_wmask = '0; m_we = 1'b0;
      for (int it = 0; it < 60; it++) begin
         if (!if_pend && $urandom_range(0, 2) != 0) begin
            if_pend = 1'b1;
            m_if_addr = {$urandom, $urandom} & ~64'h3;
         end
         if (!ls_pend && ($urandom_range(0, 2) != 0 || !if_pend)) begin
            ls_pend = 1'b1;
            m_ls_addr = {$urandom, $urandom} & ~64'h7;
            m_we = 1'($urandom_range(0, 1));
            m_wdata = {$urandom, $urandom};
            m_wmask = 8'($urandom_range(0, 255));
         end
         pick_if = if_pend && (!ls_pend || starve == STARVE);
         v.if_req = if_pend; v.if_addr = m_if_addr;
         v.ls_req = ls_pend; v.ls_we = m_we; v.ls_addr = m_ls_addr;
         v.ls_wdata = m_wdata; v.ls_wmask = m_wmask;
         v.rdy_dly = $urandom_range(0, 3);
         v.rv_dly  = $urandom_range(0, 3);
         v.rsp = {$urandom, $urandom};
         v.tmo = 1'b0;
         v.exp_ls    = !pick_if;
         v.exp_addr  = pick_if ? m_if_addr : m_ls_addr;
         v.exp_we    = pick_if ? 1'b0 : m_we;
         v.exp_wmask = pick_if ? 8'h00 : m_wmask;
         v.exp_wdata = pick_if ? 64'h0 : m_wdata;
         v.exp_rdata = v.rsp;
         v.exp_err   = 1'b0;
         if (pick_if) starve = 0;
         else if (if_pend) starve = (starve == STARVE) ? STARVE : starve + 1;
         else starve = 0;
         if (pick_if) if_pend = 1'b0;
         else ls_pend = 1'b0;
         do_txn(v);
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      cycle();
      chk("final_ack_clear", if_ack | ls_ack | err, 1'b0);
      chk("final_stall", stall, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
